// File: rtl/trace_pkg.sv
// Shared types and widths for the WB/MEM commit trace buffer.
// Build option: TRACE_TIMESTAMP_EN adds a 32-bit enqueue cycle stamp to every entry.
package trace_pkg;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_DM  = 1'b1;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CYC_W  = 32;

  typedef struct packed {
    logic              kind;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
`ifdef TRACE_TIMESTAMP_EN
    logic [CYC_W-1:0]  cyc;
`endif
  } trace_entry_t;

  localparam int unsigned ENTRY_W = $bits(trace_entry_t);

  function automatic logic [ADDR_W-1:0] pack_grf_addr(input logic [4:0] reg_idx);
    return {27'b0, reg_idx};
  endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Circular FIFO accepting up to two writes and one read per cycle, with occupancy count.
// Callers must never write more entries than there are free slots.
module trace_fifo_2w1r #(
  parameter int unsigned WIDTH = 97,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr0_en,
  input  logic [WIDTH-1:0] wr0_data,
  input  logic             wr1_en,
  input  logic [WIDTH-1:0] wr1_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr1_ptr;
  logic             do_rd;

  assign valid   = |count;
  assign do_rd   = rd_en & valid;
  // Second write lands after the first only when the first slot is used.
  assign wr1_ptr = wr_ptr + PTR_W'(wr0_en);
  // Head is masked so nothing stale or uninitialised appears while empty.
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr_ptr]  <= wr0_data;
    if (wr1_en) mem[wr1_ptr] <= wr1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr0_en) + PTR_W'(wr1_en);
      rd_ptr <= rd_ptr + PTR_W'(do_rd);
      count  <= count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(do_rd);
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Commit trace buffer: queues GRF (WB) and DM (MEM) writes in program order, drains one per cycle.
// Build option: TRACE_TIMESTAMP_EN enables the free-running cycle stamp on trc_cyc.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grf_we,
  input  logic [31:0]      grf_pc,
  input  logic [4:0]       grf_addr,
  input  logic [31:0]      grf_wd,
  input  logic             dm_we,
  input  logic [31:0]      dm_pc,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_wd,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic             trc_kind,
  output logic [31:0]      trc_pc,
  output logic [31:0]      trc_addr,
  output logic [31:0]      trc_data,
  output logic [31:0]      trc_cyc,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(DEPTH);

  trace_entry_t   grf_entry;
  trace_entry_t   dm_entry;
  trace_entry_t   head;
  logic [ENTRY_W-1:0] head_raw;
  logic           grf_ev;
  logic           pop;
  logic [CNT_W:0] free;
  logic           acc_grf;
  logic           acc_dm;
  logic           drop;

`ifdef TRACE_TIMESTAMP_EN
  logic [CYC_W-1:0] cyc_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_cnt <= '0;
    else        cyc_cnt <= cyc_cnt + 1'b1;
  end
`endif

  always_comb begin
    grf_entry      = '0;
    grf_entry.kind = KIND_GRF;
    grf_entry.pc   = grf_pc;
    grf_entry.addr = pack_grf_addr(grf_addr);
    grf_entry.data = grf_wd;
    dm_entry       = '0;
    dm_entry.kind  = KIND_DM;
    dm_entry.pc    = dm_pc;
    dm_entry.addr  = dm_addr;
    dm_entry.data  = dm_wd;
`ifdef TRACE_TIMESTAMP_EN
    grf_entry.cyc  = cyc_cnt;
    dm_entry.cyc   = cyc_cnt;
`endif
  end

  // Writes to $zero are architectural no-ops and never enter the trace.
  assign grf_ev = grf_we & (|grf_addr);
  assign pop    = trc_valid & trc_ready;
  assign free   = DEPTH_V - {1'b0, count} + {{CNT_W{1'b0}}, pop};

  // The older WB instruction claims space first; DM takes what remains.
  assign acc_grf = grf_ev & (|free);
  assign acc_dm  = dm_we & (acc_grf ? (free >= (CNT_W+1)'(2)) : (|free));
  assign drop    = (grf_ev & ~acc_grf) | (dm_we & ~acc_dm);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  trace_fifo_2w1r #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr0_en  (acc_grf | acc_dm),
    .wr0_data(acc_grf ? grf_entry : dm_entry),
    .wr1_en  (acc_grf & acc_dm),
    .wr1_data(dm_entry),
    .rd_en   (trc_ready),
    .rd_data (head_raw),
    .valid   (trc_valid),
    .count   (count)
  );

  assign head     = trace_entry_t'(head_raw);
  assign trc_kind = head.kind;
  assign trc_pc   = head.pc;
  assign trc_addr = head.addr;
  assign trc_data = head.data;
`ifdef TRACE_TIMESTAMP_EN
  assign trc_cyc  = head.cyc;
`else
  assign trc_cyc  = '0;
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer with hand-computed expectations.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        grf_we = 1'b0;
  logic [31:0] grf_pc = '0;
  logic [4:0]  grf_addr = '0;
  logic [31:0] grf_wd = '0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_pc = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wd = '0;
  logic        trc_ready = 1'b0;
  logic        trc_valid;
  logic        trc_kind;
  logic [31:0] trc_pc;
  logic [31:0] trc_addr;
  logic [31:0] trc_data;
  logic [31:0] trc_cyc;
  logic [4:0]  count;
  logic        overflow;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  wb_trace_buffer #(.DEPTH(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wd(grf_wd),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_kind(trc_kind),
    .trc_pc(trc_pc), .trc_addr(trc_addr), .trc_data(trc_data), .trc_cyc(trc_cyc),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    grf_we = 1'b0;
    dm_we  = 1'b0;
  endtask

  // Pattern event i: even -> GRF reg i+1, odd -> DM at 0x200+4i.
  task automatic drive_pattern(input int unsigned i, input logic [31:0] base);
    clear_in();
    if (i % 2 == 0) begin
      grf_we = 1'b1; grf_pc = base + 4*i; grf_addr = 5'(i + 1); grf_wd = 32'hA000 + i;
    end else begin
      dm_we = 1'b1; dm_pc = base + 4*i; dm_addr = 32'h200 + 4*i; dm_wd = 32'hB000 + i;
    end
  endtask

  task automatic expect_pattern(input int unsigned i, input logic [31:0] base);
    check_eq("drain_valid", 32'(trc_valid), 32'd1);
    check_eq("drain_pc", trc_pc, base + 4*i);
    if (i % 2 == 0) begin
      check_eq("drain_kind", 32'(trc_kind), 32'd0);
      check_eq("drain_addr", trc_addr, 32'(i + 1));
      check_eq("drain_data", trc_data, 32'hA000 + i);
    end else begin
      check_eq("drain_kind", 32'(trc_kind), 32'd1);
      check_eq("drain_addr", trc_addr, 32'h200 + 4*i);
      check_eq("drain_data", trc_data, 32'hB000 + i);
    end
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_async_valid", 32'(trc_valid), 32'd0);
    check_eq("rst_async_count", 32'(count), 32'd0);
    #3 reset = 1'b1;
    step();
  endtask

  initial begin
    // Reset state
    step();
    check_eq("rst_valid", 32'(trc_valid), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_pc", trc_pc, 32'd0);
    check_eq("rst_data", trc_data, 32'd0);
    reset = 1'b1;
    step();

    // 1: single GRF event, one cycle latency
    trc_ready = 1'b1;
    grf_we = 1'b1; grf_pc = 32'h3000; grf_addr = 5'd5; grf_wd = 32'h1234;
    step();
    clear_in();
    check_eq("t1_valid", 32'(trc_valid), 32'd1);
    check_eq("t1_kind", 32'(trc_kind), 32'd0);
    check_eq("t1_addr", trc_addr, 32'd5);
    check_eq("t1_data", trc_data, 32'h1234);
    check_eq("t1_pc", trc_pc, 32'h3000);
`ifndef TRACE_TIMESTAMP_EN
    check_eq("t1_cyc", trc_cyc, 32'd0);
`endif
    step();
    check_eq("t1_valid_after", 32'(trc_valid), 32'd0);

    // 2: same-cycle GRF + DM, GRF first
    grf_we = 1'b1; grf_pc = 32'h3004; grf_addr = 5'd8; grf_wd = 32'h55;
    dm_we = 1'b1; dm_pc = 32'h3008; dm_addr = 32'h10; dm_wd = 32'd7;
    step();
    clear_in();
    check_eq("t2_count", 32'(count), 32'd2);
    check_eq("t2a_kind", 32'(trc_kind), 32'd0);
    check_eq("t2a_pc", trc_pc, 32'h3004);
    check_eq("t2a_addr", trc_addr, 32'd8);
    check_eq("t2a_data", trc_data, 32'h55);
    step();
    check_eq("t2b_valid", 32'(trc_valid), 32'd1);
    check_eq("t2b_kind", 32'(trc_kind), 32'd1);
    check_eq("t2b_pc", trc_pc, 32'h3008);
    check_eq("t2b_addr", trc_addr, 32'h10);
    check_eq("t2b_data", trc_data, 32'd7);
    step();
    check_eq("t2_empty", 32'(trc_valid), 32'd0);

    // 3: write to $zero ignored
    grf_we = 1'b1; grf_pc = 32'h300C; grf_addr = 5'd0; grf_wd = 32'hDEAD;
    step();
    clear_in();
    check_eq("t3_count", 32'(count), 32'd0);
    check_eq("t3_overflow", 32'(overflow), 32'd0);
    check_eq("t3_valid", 32'(trc_valid), 32'd0);

    // 4: fill with ready=0, extra pair dropped, drain in order
    trc_ready = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      drive_pattern(i, 32'h4000);
      step();
    end
    clear_in();
    check_eq("t4_full_count", 32'(count), 32'd16);
    check_eq("t4_no_ovf_yet", 32'(overflow), 32'd0);
    check_eq("t4_held_pc", trc_pc, 32'h4000);
    grf_we = 1'b1; grf_pc = 32'h4F00; grf_addr = 5'd9; grf_wd = 32'hEEEE;
    dm_we = 1'b1; dm_pc = 32'h4F04; dm_addr = 32'h40; dm_wd = 32'hFFFF;
    step();
    clear_in();
    check_eq("t4_count", 32'(count), 32'd16);
    check_eq("t4_overflow", 32'(overflow), 32'd1);
    trc_ready = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      expect_pattern(i, 32'h4000);
      step();
    end
    check_eq("t4_drained", 32'(trc_valid), 32'd0);
    check_eq("t4_ovf_sticky", 32'(overflow), 32'd1);

    // 5: full with pop in same cycle -> GRF taken, DM dropped
    pulse_reset();
    check_eq("t5_ovf_cleared", 32'(overflow), 32'd0);
    trc_ready = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      drive_pattern(i, 32'h5000);
      step();
    end
    trc_ready = 1'b1;
    grf_we = 1'b1; grf_pc = 32'h6000; grf_addr = 5'd3; grf_wd = 32'h66;
    dm_we = 1'b1; dm_pc = 32'h6004; dm_addr = 32'h80; dm_wd = 32'h77;
    step();
    clear_in();
    check_eq("t5_count", 32'(count), 32'd16);
    check_eq("t5_overflow", 32'(overflow), 32'd1);
    expect_pattern(1, 32'h5000);
    for (int unsigned i = 0; i < 15; i++) step();
    check_eq("t5_last_kind", 32'(trc_kind), 32'd0);
    check_eq("t5_last_pc", trc_pc, 32'h6000);
    check_eq("t5_last_addr", trc_addr, 32'd3);
    check_eq("t5_last_data", trc_data, 32'h66);
    step();
    check_eq("t5_dm_dropped", 32'(trc_valid), 32'd0);

    // 6: reset mid-drain, then timestamp of a post-reset event
    trc_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      drive_pattern(i, 32'h7000);
      step();
    end
    clear_in();
    trc_ready = 1'b1;
    step();
    check_eq("t6_count_mid", 32'(count), 32'd3);
    pulse_reset();
    check_eq("t6_count_post", 32'(count), 32'd0);
    step();
    step();
    grf_we = 1'b1; grf_pc = 32'h8000; grf_addr = 5'd1; grf_wd = 32'h1;
    step();
    clear_in();
    check_eq("t6_valid", 32'(trc_valid), 32'd1);
    check_eq("t6_pc", trc_pc, 32'h8000);
`ifdef TRACE_TIMESTAMP_EN
    check_eq("t6_cyc", trc_cyc, 32'd3);
`else
    check_eq("t6_cyc", trc_cyc, 32'd0);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
